// File: rtl/br_predict_unit_if.sv
// Fetch-lookup and execute-resolution bundle for br_predict_unit.
// The master side is the pipeline (fetch + execute) and the slave side is the predictor.
interface br_predict_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            br_sig;
    logic [2:0]      br_op;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            res_valid;
    logic            res_taken;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            mispredict;

    modport master (
        output f_pc, ex_valid, ex_pc, ex_imm, rs1, rs2, br_sig, br_op,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, res_valid, res_taken, redirect_pc,
               pc_plus4, mispredict
    );

    modport slave (
        input  f_pc, ex_valid, ex_pc, ex_imm, rs1, rs2, br_sig, br_op,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, res_valid, res_taken, redirect_pc,
               pc_plus4, mispredict
    );
endinterface

// File: rtl/br_predict_unit.sv
// Branch resolution unit with a direct-mapped history/target table.
// Fetch looks up combinationally; execute resolves, trains and reports registered results.
module br_predict_unit #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 64,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    br_predict_unit_if.slave bus,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];

    logic             r_res_valid;
    logic             r_res_taken;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [XLEN-1:0]  r_pc_plus4;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_mispred_count;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_cond;
    logic             w_taken;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_pc4;
    logic [XLEN-1:0]  w_next;
    logic             w_mispred;
    logic             w_train;

    assign w_f_idx  = bus.f_pc[IDX_W+1:2];
    assign w_f_tag  = bus.f_pc[XLEN-1:IDX_W+2];
    assign w_ex_idx = bus.ex_pc[IDX_W+1:2];
    assign w_ex_tag = bus.ex_pc[XLEN-1:IDX_W+2];

    // Fetch-side lookup; valid bits clear asynchronously so a reset kills prediction at once.
    always_comb begin
        w_f_hit         = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
        bus.pred_taken  = w_f_hit & r_ctr[w_f_idx][1];
        if (w_f_hit) begin
            bus.pred_target = r_target[w_f_idx];
        end else begin
            bus.pred_target = bus.f_pc + XLEN'(3'd4);
        end
    end

    // Execute-side condition, target, next PC and mispredict detection.
    always_comb begin
        w_cond = 1'b0;
        case (bus.br_op)
            3'd0:    w_cond = (bus.rs1 == bus.rs2);
            3'd1:    w_cond = (bus.rs1 != bus.rs2);
            3'd2:    w_cond = ($signed(bus.rs1) <  $signed(bus.rs2));
            3'd3:    w_cond = ($signed(bus.rs1) >= $signed(bus.rs2));
            3'd4:    w_cond = (bus.rs1 <  bus.rs2);
            3'd5:    w_cond = (bus.rs1 >= bus.rs2);
            3'd6:    w_cond = 1'b1;
            3'd7:    w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
        if (bus.br_op == 3'd7) begin
            w_target = (bus.rs1 + bus.ex_imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end else begin
            w_target = bus.ex_pc + bus.ex_imm;
        end
        w_pc4   = bus.ex_pc + XLEN'(3'd4);
        w_taken = bus.br_sig & w_cond;
        if (w_taken) begin
            w_next = w_target;
        end else begin
            w_next = w_pc4;
        end
        w_mispred = bus.ex_valid &
                    ((w_taken != bus.ex_pred_taken) |
                     (w_taken & (bus.ex_pred_target != w_target)));
        w_train   = bus.ex_valid & bus.br_sig;
        w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    end

    // Table training: saturating counter on hit, allocate strongly-ish taken on taken miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= CTR_INIT;
                r_target[i] <= '0;
            end
        end else if (w_train) begin
            if (w_ex_hit) begin
                if (w_taken) begin
                    r_ctr[w_ex_idx]    <= (r_ctr[w_ex_idx] == 2'b11) ? 2'b11 : r_ctr[w_ex_idx] + 2'b01;
                    r_target[w_ex_idx] <= w_target;
                end else begin
                    r_ctr[w_ex_idx]    <= (r_ctr[w_ex_idx] == 2'b00) ? 2'b00 : r_ctr[w_ex_idx] - 2'b01;
                end
            end else if (w_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_ctr[w_ex_idx]    <= 2'b10;
                r_target[w_ex_idx] <= w_target;
            end
        end
    end

    // Resolution registers; data fields hold while execute is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_taken   <= 1'b0;
            r_redirect_pc <= '0;
            r_pc_plus4    <= '0;
            r_mispredict  <= 1'b0;
        end else if (bus.ex_valid) begin
            r_res_valid   <= 1'b1;
            r_res_taken   <= w_taken;
            r_redirect_pc <= w_next;
            r_pc_plus4    <= w_pc4;
            r_mispredict  <= w_mispred;
        end else begin
            r_res_valid   <= 1'b0;
            r_mispredict  <= 1'b0;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_train && (r_br_count != {CNT_W{1'b1}})) begin
                r_br_count <= r_br_count + CNT_W'(1'b1);
            end
            if (w_mispred && (r_mispred_count != {CNT_W{1'b1}})) begin
                r_mispred_count <= r_mispred_count + CNT_W'(1'b1);
            end
        end
    end

    assign bus.res_valid   = r_res_valid;
    assign bus.res_taken   = r_res_taken;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.pc_plus4    = r_pc_plus4;
    assign bus.mispredict  = r_mispredict;
    assign br_count        = r_br_count;
    assign mispred_count   = r_mispred_count;
endmodule

// File: tb/tb_br_predict_unit.sv
// Directed bench for br_predict_unit with hand-computed expectations and 4-bit counters.
module tb_br_predict_unit;
    logic       clk;
    logic       rst;
    logic [3:0] br_count;
    logic [3:0] mispred_count;
    int         n_total;
    int         n_bad;
    int         exp_br;
    int         exp_mis;

    br_predict_unit_if #(.XLEN(32)) bus ();

    br_predict_unit #(
        .XLEN(32), .ENTRIES(64), .CTR_INIT(2'b01), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic e_taken, input logic [31:0] e_tgt);
        bus.f_pc = pc;
        #1;
        chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, e_taken});
        chk("pred_target", bus.pred_target, e_tgt);
    endtask

    task automatic exec(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op, input logic br,
                        input logic pt, input logic [31:0] ptgt, input logic e_taken,
                        input logic [31:0] e_redir, input logic e_mis);
        bus.ex_valid       = 1'b1;
        bus.ex_pc          = pc;
        bus.ex_imm         = imm;
        bus.rs1            = a;
        bus.rs2            = b;
        bus.br_op          = op;
        bus.br_sig         = br;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptgt;
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        if (br && exp_br != 15) exp_br++;
        if (e_mis && exp_mis != 15) exp_mis++;
        chk("res_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("res_taken", {31'd0, bus.res_taken}, {31'd0, e_taken});
        chk("redirect_pc", bus.redirect_pc, e_redir);
        chk("pc_plus4", bus.pc_plus4, pc + 32'd4);
        chk("mispredict", {31'd0, bus.mispredict}, {31'd0, e_mis});
        chk("br_count", {28'd0, br_count}, exp_br);
        chk("mispred_count", {28'd0, mispred_count}, exp_mis);
    endtask

    initial begin
        n_total = 0; n_bad = 0; exp_br = 0; exp_mis = 0;
        rst = 1'b1;
        bus.f_pc = 32'h100; bus.ex_valid = 1'b0; bus.ex_pc = 32'd0; bus.ex_imm = 32'd0;
        bus.rs1 = 32'd0; bus.rs2 = 32'd0; bus.br_sig = 1'b0; bus.br_op = 3'd0;
        bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        look(32'h100, 1'b0, 32'h104);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_taken", {31'd0, bus.res_taken}, 32'd0);
        chk("rst_redirect", bus.redirect_pc, 32'd0);
        chk("rst_pc_plus4", bus.pc_plus4, 32'd0);
        chk("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk("rst_br_count", {28'd0, br_count}, 32'd0);
        chk("rst_mispred_count", {28'd0, mispred_count}, 32'd0);

        // BEQ taken, predicted not-taken: allocates at 0x100
        exec(32'h100, 32'h20, 32'd5, 32'd5, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h120, 1'b1);
        look(32'h100, 1'b1, 32'h120);
        @(posedge clk);
        #1;
        chk("idle_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("idle_mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk("idle_redirect_hold", bus.redirect_pc, 32'h120);

        exec(32'h200, 32'h40, 32'd1, 32'hFFFF_FFFF, 3'd4, 1'b1, 1'b0, 32'd0, 1'b1, 32'h240, 1'b1);
        exec(32'h300, 32'h40, 32'd1, 32'hFFFF_FFFF, 3'd2, 1'b1, 1'b0, 32'd0, 1'b0, 32'h304, 1'b0);
        look(32'h300, 1'b0, 32'h304);
        exec(32'h400, 32'h10, 32'd7, 32'd7, 3'd5, 1'b1, 1'b1, 32'h410, 1'b1, 32'h410, 1'b0);
        look(32'h400, 1'b1, 32'h410);
        exec(32'h500, 32'h10, 32'd3, 32'd3, 3'd1, 1'b1, 1'b0, 32'd0, 1'b0, 32'h504, 1'b0);
        exec(32'h504, 32'h10, 32'hFFFF_FFFF, 32'd1, 3'd3, 1'b1, 1'b0, 32'd0, 1'b0, 32'h508, 1'b0);
        exec(32'h600, 32'd2, 32'h1001, 32'd0, 3'd7, 1'b1, 1'b1, 32'h1002, 1'b1, 32'h1002, 1'b0);
        exec(32'h600, 32'd2, 32'h1001, 32'd0, 3'd7, 1'b1, 1'b1, 32'h1000, 1'b1, 32'h1002, 1'b1);
        exec(32'h608, 32'hFFFF_FFF8, 32'd0, 32'd0, 3'd6, 1'b1, 1'b0, 32'd0, 1'b1, 32'h600, 1'b1);
        // Non-branch predicted taken through aliasing
        exec(32'h800, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 32'h900, 1'b0, 32'h804, 1'b1);

        // Counter walk at 0x700: 10, 11, then down to 00 and back up
        exec(32'h700, 32'h80, 32'd1, 32'd1, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h780, 1'b1);
        look(32'h700, 1'b1, 32'h780);
        exec(32'h700, 32'h80, 32'd1, 32'd1, 3'd0, 1'b1, 1'b1, 32'h780, 1'b1, 32'h780, 1'b0);
        look(32'h700, 1'b1, 32'h780);
        exec(32'h700, 32'h80, 32'd1, 32'd2, 3'd0, 1'b1, 1'b1, 32'h780, 1'b0, 32'h704, 1'b1);
        look(32'h700, 1'b1, 32'h780);
        exec(32'h700, 32'h80, 32'd1, 32'd2, 3'd0, 1'b1, 1'b1, 32'h780, 1'b0, 32'h704, 1'b1);
        look(32'h700, 1'b0, 32'h780);
        exec(32'h700, 32'h80, 32'd1, 32'd2, 3'd0, 1'b1, 1'b0, 32'h780, 1'b0, 32'h704, 1'b0);
        look(32'h700, 1'b0, 32'h780);
        exec(32'h700, 32'h80, 32'd1, 32'd2, 3'd0, 1'b1, 1'b0, 32'h780, 1'b0, 32'h704, 1'b0);
        look(32'h700, 1'b0, 32'h780);
        exec(32'h700, 32'h80, 32'd1, 32'd1, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h780, 1'b1);
        look(32'h700, 1'b0, 32'h780);
        exec(32'h700, 32'h80, 32'd1, 32'd1, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h780, 1'b1);
        look(32'h700, 1'b1, 32'h780);

        // Same-edge lookup sees old contents; new allocation evicts 0x700 at index 0
        look(32'hA00, 1'b0, 32'hA04);
        exec(32'hA00, 32'h100, 32'd2, 32'd2, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hB00, 1'b1);
        look(32'hA00, 1'b1, 32'hB00);
        look(32'h700, 1'b0, 32'h704);

        // Reset asserted while a taken branch waits for the edge
        bus.ex_valid = 1'b1; bus.ex_pc = 32'hB00; bus.ex_imm = 32'h40;
        bus.rs1 = 32'd4; bus.rs2 = 32'd4; bus.br_op = 3'd0; bus.br_sig = 1'b1;
        bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'd0; bus.f_pc = 32'hA00;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        chk("arst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("arst_res_taken", {31'd0, bus.res_taken}, 32'd0);
        chk("arst_redirect", bus.redirect_pc, 32'd0);
        chk("arst_pc_plus4", bus.pc_plus4, 32'd0);
        chk("arst_mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk("arst_br_count", {28'd0, br_count}, 32'd0);
        chk("arst_mispred_count", {28'd0, mispred_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ex_valid = 1'b0;
        exp_br = 0; exp_mis = 0;
        look(32'hB00, 1'b0, 32'hB04);
        look(32'hA00, 1'b0, 32'hA04);

        // Counter saturation at 4 bits
        for (int i = 0; i < 17; i++) begin
            exec(32'hC00, 32'h10, 32'd9, 32'd9, 3'd0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hC10, 1'b1);
        end
        chk("sat_br_count", {28'd0, br_count}, 32'd15);
        chk("sat_mispred_count", {28'd0, mispred_count}, 32'd15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
